// File: rtl/sel_combine_pipe.sv
// -----------------------------------------------------------------------------
// sel_combine_pipe
//
// Purpose:
//   Two-stage select/combine pipeline with a saturating running accumulator.
//   S1 applies a mode-selected bitwise function to every channel's operand pair.
//   S2 reduces all channel results to an unsigned sum and a parity bit.
//   Every output handshake adds out_sum into a saturating accumulator.
//   Valid/ready flow control is used on both sides, with full throughput.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_a       channel i operand A = in_a[i*W +: W]
//   in_b       channel i operand B = in_b[i*W +: W]
//   mode       00 AND, 01 OR, 10 XOR, 11 A&~B; captured with the beat
//   clr_acc    synchronous accumulator clear; applied before a same-cycle add
//   chan_mask  (only with SCP_CHAN_MASK_EN) per-channel enable, captured with the beat
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   out_sum    unsigned sum of all channel results
//   out_par    XOR-reduction of all channel result bits
//   acc        running saturating sum of consumed out_sum values
//   acc_sat    sticky saturation flag
//
// Configuration macro:
//   SCP_CHAN_MASK_EN  adds the chan_mask input. A masked channel (bit=0) forces
//                     its result to zero.
// -----------------------------------------------------------------------------
module sel_combine_pipe #(
    parameter int NCH   = 4,
    parameter int W     = 8,
    parameter int ACC_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NCH*W-1:0]           in_a,
    input  logic [NCH*W-1:0]           in_b,
    input  logic [1:0]                 mode,
    input  logic                       clr_acc,
`ifdef SCP_CHAN_MASK_EN
    input  logic [NCH-1:0]             chan_mask,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W+$clog2(NCH)-1:0]   out_sum,
    output logic                       out_par,
    output logic [ACC_W-1:0]           acc,
    output logic                       acc_sat
);

    localparam int SW = W + $clog2(NCH);

    // Per-channel bitwise function selected by mode.
    function automatic logic [W-1:0] sel_op(input logic [1:0] m,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        case (m)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a & ~b;
        endcase
        return r;
    endfunction

    // Saturating add. The MSB of the result flags an overflow. The low ACC_W
    // bits hold either the exact sum or the clamped maximum.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                               input logic [SW-1:0]    add);
        logic [ACC_W:0] wide;
        wide = {1'b0, base} + (ACC_W+1)'(add);
        if (wide[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return wide;
    endfunction

    logic [NCH-1:0]   en;
`ifdef SCP_CHAN_MASK_EN
    assign en = chan_mask;
`else
    assign en = '1;
`endif

    logic             vld_p1_q;
    logic [NCH*W-1:0] f_p1_q;
    logic [NCH*W-1:0] f_d;
    logic             vld_p2_q;
    logic [SW-1:0]    sum_p2_q;
    logic [SW-1:0]    sum_d;
    logic             par_p2_q;
    logic             par_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             acc_sat_q;
    logic             acc_sat_d;

    logic             ld_p1;
    logic             ld_p2;
    logic             out_hs;

    // A stage loads when it is empty or when its contents move on this cycle.
    // in_ready therefore depends combinationally on out_ready, which sustains
    // one beat per cycle.
    assign ld_p2    = !vld_p2_q || out_ready;
    assign ld_p1    = !vld_p1_q || ld_p2;
    assign in_ready = ld_p1;
    assign out_hs   = vld_p2_q && out_ready;

    // ---- Stage 1: per-channel function (mode and mask sampled with the beat)
    always_comb begin
        f_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) begin
                f_d[i*W +: W] = sel_op(mode, in_a[i*W +: W], in_b[i*W +: W]);
            end
        end
    end

    // ---- Stage 2: reduction. SW bits hold NCH*(2^W-1), so the sum cannot overflow.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_d = sum_d + SW'(f_p1_q[i*W +: W]);
        end
        par_d = ^f_p1_q;
    end

    // Accumulator: clear first, then add the consumed result.
    always_comb begin
        logic [ACC_W-1:0] base;
        logic             sat_base;
        logic [ACC_W:0]   res;
        base      = clr_acc ? '0 : acc_q;
        sat_base  = clr_acc ? 1'b0 : acc_sat_q;
        res       = '0;
        acc_d     = base;
        acc_sat_d = sat_base;
        if (out_hs) begin
            res       = sat_add(base, out_sum);
            acc_d     = res[ACC_W-1:0];
            acc_sat_d = sat_base | res[ACC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            f_p1_q    <= '0;
            vld_p2_q  <= 1'b0;
            sum_p2_q  <= '0;
            par_p2_q  <= 1'b0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else begin
            if (ld_p1) begin
                vld_p1_q <= in_valid;
                f_p1_q   <= f_d;
            end
            if (ld_p2) begin
                vld_p2_q <= vld_p1_q;
                sum_p2_q <= sum_d;
                par_p2_q <= par_d;
            end
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_sum   = sum_p2_q;
    assign out_par   = par_p2_q;
    assign acc       = acc_q;
    assign acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_sel_combine_pipe.sv
// -----------------------------------------------------------------------------
// tb_sel_combine_pipe
//
// Directed testbench for sel_combine_pipe (NCH=4, W=8, ACC_W=10).
// Inputs change 1 time unit after the rising edge. Outputs are read later in
// the same cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sel_combine_pipe;

    localparam int NCH   = 4;
    localparam int W     = 8;
    localparam int ACC_W = 10;
    localparam int SW    = W + $clog2(NCH);

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [NCH*W-1:0]   in_a;
    logic [NCH*W-1:0]   in_b;
    logic [1:0]         mode;
    logic               clr_acc;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      out_sum;
    logic               out_par;
    logic [ACC_W-1:0]   acc;
    logic               acc_sat;
`ifdef SCP_CHAN_MASK_EN
    logic [NCH-1:0]     chan_mask;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sel_combine_pipe #(.NCH(NCH), .W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mode      (mode),
        .clr_acc   (clr_acc),
`ifdef SCP_CHAN_MASK_EN
        .chan_mask (chan_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_par   (out_par),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the streaming section: the channel function and its reductions.
    function automatic logic [SW-1:0] ref_sum(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [SW-1:0] s;
        logic [7:0]    x, y, r;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            x = a[c*8 +: 8];
            y = b[c*8 +: 8];
            case (m)
                2'b00:   r = x & y;
                2'b01:   r = x | y;
                2'b10:   r = x ^ y;
                default: r = x & ~y;
            endcase
            s = s + {2'b00, r};
        end
        return s;
    endfunction

    // Streaming stimulus
    logic [31:0] st_a [8] = '{32'h01020304, 32'hFFFFFFFF, 32'h80808080, 32'h12345678,
                              32'hAAAAAAAA, 32'h0F0F0F0F, 32'h00000000, 32'hFEDCBA98};
    logic [31:0] st_b [8] = '{32'hFFFFFFFF, 32'h0F0F0F0F, 32'h01010101, 32'h87654321,
                              32'h55555555, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h11111111};
    logic [1:0]  st_m [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SW-1:0] expq[$];
        int  nsent;
        int  nrecv;
        int  last_cyc;
        bit  saw_bp;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; mode = 2'b00;
        clr_acc = 1'b0; out_ready = 1'b1;
`ifdef SCP_CHAN_MASK_EN
        chan_mask = '1;
`endif
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum",   out_sum,   0);
        chk("rst_out_par",   out_par,   0);
        chk("rst_acc",       acc,       0);
        chk("rst_acc_sat",   acc_sat,   0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // AND: 0xFF & 0x0F = 15 per channel, 60 in total, with 16 ones (even parity).
        in_valid = 1'b1; mode = 2'b00; in_a = 32'hFFFFFFFF; in_b = 32'h0F0F0F0F;
        step();
        in_valid = 1'b0;
        chk("and_lat1_valid", out_valid, 0);
        step();
        chk("and_valid", out_valid, 1);
        chk("and_sum",   out_sum,   60);
        chk("and_par",   out_par,   0);
        step();
        chk("and_acc",       acc,       60);
        chk("and_drained",   out_valid, 0);

        clr_acc = 1'b1;
        step();
        clr_acc = 1'b0;
        chk("clr_acc", acc, 0);

        // XOR: 0xAA ^ 0x55 = 0xFF, giving 1020. A&~B: 0xAA & 0xAA = 0xAA, giving 680.
        in_valid = 1'b1; mode = 2'b10; in_a = 32'hAAAAAAAA; in_b = 32'h55555555;
        step();
        mode = 2'b11;
        step();
        in_valid = 1'b0;
        chk("xor_sum", out_sum, 1020);
        chk("xor_par", out_par, 0);
        step();
        chk("andn_sum",  out_sum, 680);
        chk("andn_par",  out_par, 0);
        chk("acc_1020",  acc,     1020);
        chk("sat0",      acc_sat, 0);
        step();
        chk("acc_clamp", acc,     1023);
        chk("sat1",      acc_sat, 1);

        // 1020 consumed while clr_acc is high: clear first, then add.
        in_valid = 1'b1; mode = 2'b10;
        step();
        in_valid = 1'b0;
        step();
        clr_acc = 1'b1;
        step();
        clr_acc = 1'b0;
        chk("clr_hs_acc", acc,     1020);
        chk("clr_hs_sat", acc_sat, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("resat_acc", acc,     1023);
        chk("resat_sat", acc_sat, 1);

        // Odd-parity beat (channel 0 = 1). The accumulator stays saturated.
        in_valid = 1'b1; mode = 2'b01; in_a = 32'h00000001; in_b = 32'h00000000;
        step();
        in_valid = 1'b0;
        step();
        chk("one_sum", out_sum, 1);
        chk("one_par", out_par, 1);
        step();
        chk("held_acc", acc,     1023);
        chk("held_sat", acc_sat, 1);

        // Stream of 8 beats with out_ready low for 3 cycles.
        nsent = 0; nrecv = 0; last_cyc = -1; saw_bp = 1'b0;
        for (int cyc = 0; cyc < 40 && nrecv < 8; cyc++) begin
            in_valid = (nsent < 8);
            if (nsent < 8) begin
                in_a = st_a[nsent]; in_b = st_b[nsent]; mode = st_m[nsent];
            end
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (in_valid && !in_ready) saw_bp = 1'b1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("stream_extra", 1, 0);
                end else begin
                    chk("stream_sum", out_sum, expq.pop_front());
                end
                nrecv++;
                last_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_sum(mode, in_a, in_b));
                nsent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count",    nrecv,    8);
        chk("stream_backpres", saw_bp,   1);
        chk("stream_last_cyc", last_cyc, 12);

        // Mode changes while the pipe is stalled must not affect captured beats.
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 2'b10; in_a = 32'hAAAAAAAA; in_b = 32'h55555555;
        step();
        mode = 2'b11;
        step();
        in_valid = 1'b0; mode = 2'b00;
        chk("stall_valid", out_valid, 1);
        chk("stall_sum0",  out_sum,   1020);
        step();
        chk("stall_sum1",  out_sum,   1020);
        chk("stall_ready", in_ready,  0);
        out_ready = 1'b1;
        #1;
        chk("ready_comb",  in_ready,  1);
        step();
        chk("stall_next",  out_sum,   680);
        step();
        chk("stall_empty", out_valid, 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 2'b00; in_a = 32'hFFFFFFFF; in_b = 32'h0F0F0F0F;
        step(); step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_acc",   acc,       0);
        chk("arst_sat",   acc_sat,   0);
        chk("arst_sum",   out_sum,   0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        step();
        chk("rel_no_ghost", out_valid, 0);
        step();
        chk("rel_no_ghost2", out_valid, 0);

`ifdef SCP_CHAN_MASK_EN
        // Channels 0 and 2 enabled: 0x01 | 0x02 = 3 each, giving 6 with 4 ones.
        chan_mask = 4'b0101; in_valid = 1'b1; mode = 2'b01;
        in_a = 32'h01010101; in_b = 32'h02020202;
        step();
        in_valid = 1'b0; chan_mask = '1;
        step();
        chk("mask_sum", out_sum, 6);
        chk("mask_par", out_par, 0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
